// File: rtl/mersenne_mac.sv
// Pipelined multiply-accumulate over Z/(2^W-1) with valid/ready streaming and grouped sums.
// Optional build macro MERSENNE_MAC_CANON_EN: forces out_acc canonical (never all-ones).
module mersenne_mac #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_clr,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_acc,
    output logic         out_zero
);

    // Handshake: a beat transfers on a rising edge where in_valid & in_ready, a result
    // where out_valid & out_ready; the whole pipeline advances only when the output
    // register is empty or being drained, so in_ready is exactly that advance signal.

    function automatic logic [W-1:0] eac_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        return s[W-1:0] + {{(W-1){1'b0}}, s[W]};
    endfunction

    logic         adv;
    logic [W-1:0] prod;
    logic [W-1:0] rot;
    logic [W-1:0] pp;
    logic [W-1:0] base;
    logic [W-1:0] sum;
    logic [W-1:0] res;

    logic         s1_valid_q, s1_valid_d;
    logic         s1_clr_q,   s1_clr_d;
    logic         s1_last_q,  s1_last_d;
    logic [W-1:0] s1_p_q,     s1_p_d;
    logic [W-1:0] acc_q,      acc_d;
    logic [W-1:0] out_acc_q,  out_acc_d;
    logic         out_valid_q, out_valid_d;

    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv;

    // Multiplying by 2^i mod 2^W-1 is a left rotation by i.
    always_comb begin
        prod = '0;
        rot  = '0;
        pp   = '0;
        for (int i = 0; i < W; i++) begin
            rot  = (in_a << i) | (in_a >> (W - i));
            pp   = in_b[i] ? rot : '0;
            prod = eac_add(prod, pp);
        end
    end

    assign base = s1_clr_q ? '0 : acc_q;
    assign sum  = eac_add(base, s1_p_q);

`ifdef MERSENNE_MAC_CANON_EN
    assign res = (sum == {W{1'b1}}) ? '0 : sum;
`else
    assign res = sum;
`endif

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_clr_d    = s1_clr_q;
        s1_last_d   = s1_last_q;
        s1_p_d      = s1_p_q;
        acc_d       = acc_q;
        out_acc_d   = out_acc_q;
        out_valid_d = out_valid_q;
        if (adv) begin
            s1_valid_d  = in_valid;
            if (in_valid) begin
                s1_clr_d  = in_clr;
                s1_last_d = in_last;
                s1_p_d    = prod;
            end
            out_valid_d = s1_valid_q & s1_last_q;
            if (s1_valid_q) begin
                if (s1_last_q) begin
                    out_acc_d = res;
                    acc_d     = '0;
                end else begin
                    acc_d = sum;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_clr_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_p_q      <= '0;
            acc_q       <= '0;
            out_acc_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_clr_q    <= s1_clr_d;
            s1_last_q   <= s1_last_d;
            s1_p_q      <= s1_p_d;
            acc_q       <= acc_d;
            out_acc_q   <= out_acc_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    // Qualified by out_valid so the idle/reset output reads as "no zero result".
    assign out_zero  = out_valid_q & ((out_acc_q == '0) | (out_acc_q == {W{1'b1}}));

endmodule

// File: doc/mersenne_mac.md
Name: mersenne_mac

Overview:
- Pipelined multiply-accumulate unit over the Mersenne ring Z/(2^W-1), parametrised in operand width W.
- Successor to the fixed 5-bit mod-31 adder, multiplier and comparator cells: it generalises the width and adds a valid/ready streaming interface and grouped accumulation.
- Sits in the execute path of the residue datapath. It consumes operand pairs and emits one reduced dot-product residue per group.

Parameters:
- W, 5, residue width; modulus M = 2^W-1; legal range 3..16.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high (fixed).
- in_valid  input  1  operand beat present.
- in_ready  output  1  beat accepted when in_valid & in_ready.
- in_a  input  W  operand A residue; all-ones is a legal encoding of 0.
- in_b  input  W  operand B residue; all-ones is a legal encoding of 0.
- in_clr  input  1  first beat of a group; discard the prior partial sum.
- in_last  input  1  last beat of a group; emit the result.
- out_valid  output  1  result present.
- out_ready  input  1  result consumed when out_valid & out_ready.
- out_acc  output  W  group sum of products mod M.
- out_zero  output  1  out_acc is congruent to 0 (out_acc equals 0 or all-ones).

Behaviour:
- Reset (async assert, sync release):
  - s1_valid, s2 accumulator, out_valid all 0.
  - out_acc = 0, out_zero = 0.
  - in_ready = 1 after reset.
  - Reset mid-group discards the partial sum and any in-flight beats.
- Global advance: adv = ~out_valid | out_ready. in_ready = adv. All stages hold when adv = 0.
- Stage 1 (registered on accepted beat):
  - Form W partial products: a rotated left by i, ANDed with b[i].
  - Sum them with end-around-carry addition (carry out of bit W-1 re-enters bit 0) to get p, congruent to a*b mod M.
  - Register p, clr, last, and s1_valid.
  - Bubbles (no accepted beat while adv = 1) clear s1_valid.
- Stage 2 (when s1_valid & adv):
  - base = clr ? 0 : acc.
  - sum = base + p with end-around carry.
  - If last: out_acc <= sum, out_valid <= 1, acc <= 0.
  - Else: acc <= sum, out_valid <= 0 unless it is held by stall.
- Output register:
  - Cleared (out_valid <= 0) on out_ready handshake when no new last arrives in the same cycle.
  - Simultaneous drain and new last: the new result is loaded and out_valid stays 1.
- Latency: a last beat accepted in cycle t gives out_valid in cycle t+2 with no stall. Throughput is 1 beat per cycle.
- Stall: while out_valid & ~out_ready:
  - out_acc and out_zero are stable.
  - in_ready = 0.
  - Pipeline contents are preserved.
- clr & last on the same beat: single-beat group; result equals that product.
- A beat with neither clr nor last after a completed group: accumulates from 0, since acc was cleared on last.
- out_zero is combinational from out_acc.

Optional Feature:
- Macro: MERSENNE_MAC_CANON_EN.
- Defined: out_acc is canonical. An all-ones result is replaced by 0 at the stage-2 output register, so out_acc is never all-ones.
- Undefined: out_acc may be all-ones, a redundant encoding of 0; no normalisation logic is generated.
- out_zero behaves identically in both builds.

Test Plan (W=5, M=31):
- Group (3,4 clr), (5,7), (30,30 last), no stall:
  - Required: out_valid exactly 2 cycles after the last beat.
  - Required: out_acc = 17, out_zero = 0.
- Single beat (7,9) with clr=last=1: out_acc = 1.
- Group (1,30 clr), (1,1 last) sums to 31:
  - Required: out_zero = 1.
  - Required: out_acc = 0 with MERSENNE_MAC_CANON_EN defined; 0 or 31 without.
- Operand encodings of 0: (31,17 clr last) gives out_zero = 1. (31,31) followed by (2,3 last) in one group gives out_acc = 6.
- Backpressure: hold out_ready = 0 for 3 cycles with a result pending and a new group streaming:
  - Required: in_ready = 0 during the hold.
  - Required: out_acc stable during the hold.
  - Required: after release, the next group's result is correct with no beat lost or duplicated.
- Reset mid-group: assert rst after (5,5 clr), then send (2,2 clr last):
  - Required: all valids 0 during reset.
  - Required: out_acc = 4 after the clr-last beat.
